// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one single-port memory with ack handshake.
// Optional WAIT timeout with sticky error flag when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_req_we,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic [DW-1:0]     o_rdata,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [AW-1:0]     o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata,
  input  logic              i_mem_ack
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("mem_arbiter: NREQ and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_widx, w_widx_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_mem_en, w_mem_en_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [31:0]     w_idx;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   r_tcnt, w_tcnt_nxt;
  logic            r_err, w_err_nxt;
`endif

  // Round-robin scan starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && i_req[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == w_win) begin
        w_sel_we    = i_req_we[k];
        w_sel_addr  = i_req_addr[k*AW +: AW];
        w_sel_wdata = i_req_wdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_widx_nxt      = r_widx;
    w_gnt_nxt       = r_gnt;
    w_done_nxt      = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
    w_tcnt_nxt      = r_tcnt;
    w_err_nxt       = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_ISSUE;
          w_widx_nxt      = w_win;
          w_gnt_nxt       = NREQ'(1) << w_win;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = w_sel_we;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        w_tcnt_nxt  = '0;
`endif
      end
      S_WAIT: begin
        if (i_mem_ack) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_gnt;
          if (!r_mem_we) w_rdata_nxt = i_mem_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_tcnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_gnt;
          w_rdata_nxt = {DW{1'b1}};
          w_err_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt  = r_tcnt + CW'(1);
        end
`endif
      end
      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_ptr_nxt       = (r_widx == PW'(NREQ - 1)) ? '0 : r_widx + PW'(1);
        w_gnt_nxt       = '0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_widx      <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_widx      <= w_widx_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_err  <= w_err_nxt;
    end
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// round-robin reference model; the timeout scenario runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  i_req, i_req_we;
  logic [47:0] i_req_addr, i_req_wdata;
  logic [2:0]  o_gnt, o_done;
  logic [15:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_busy, o_err, o_mem_en, o_mem_we, i_mem_ack;

  int n_vec = 0;
  int n_err = 0;
  int ref_ptr = 0;
  logic [15:0] ref_rdata = 16'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(3), .AW(16), .DW(16), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_busy(o_busy), .o_err(o_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_winner(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; i_mem_ack = 1'b0; i_req = '0;
    tick(); tick();
    reset = 1'b0;
    ref_ptr = 0; ref_rdata = 16'h0;
  endtask

  task automatic set_port(input int i, input logic we, input logic [15:0] a, input logic [15:0] wd);
    i_req_we[i] = we;
    i_req_addr[i*16 +: 16] = a;
    i_req_wdata[i*16 +: 16] = wd;
  endtask

  // Drives one transaction from the grant edge to the return to IDLE; lat = 0 means memory never acks.
  task automatic run_txn(input int lat, input logic [15:0] rd, input int win, input bit jitter,
                         output logic [2:0] g, output logic [2:0] d, output logic [15:0] rdat,
                         output logic [15:0] maddr, output logic mwe, output logic [15:0] mwd,
                         output int en_cnt, output int done_cyc, output bit held,
                         output bit idle_ok, output logic e);
    bit seen = 0;
    tick();
    g = o_gnt; maddr = o_mem_addr; mwe = o_mem_we; mwd = o_mem_wdata;
    en_cnt = o_mem_en ? 1 : 0;
    held = 1; done_cyc = -1; d = '0; rdat = '0; e = 1'b0; idle_ok = 0;
    for (int n = 1; n <= 600 && !seen; n++) begin
      tick();
      if (o_mem_en) en_cnt++;
      if (o_gnt !== g || o_mem_addr !== maddr || o_mem_we !== mwe || o_mem_wdata !== mwd) held = 0;
      if (o_done !== 3'b000) begin
        seen = 1; done_cyc = n; d = o_done; rdat = o_rdata; e = o_err;
        i_mem_ack = 1'b0;
      end else begin
        i_mem_ack = (n == lat);
        i_mem_rdata = (n == lat) ? rd : 16'($urandom);
        if (jitter)
          for (int i = 0; i < 3; i++)
            if (i != win) begin
              i_req[i] = 1'($urandom);
              i_req_addr[i*16 +: 16] = 16'($urandom);
            end
      end
    end
    if (seen) begin
      tick();
      idle_ok = (o_busy === 1'b0 && o_gnt === 3'b000 && o_done === 3'b000 && o_mem_en === 1'b0);
    end
  endtask

  task automatic test_reset();
    i_req = '0; i_req_we = '0; i_req_addr = '0; i_req_wdata = '0;
    i_mem_rdata = '0; i_mem_ack = 1'b0;
    do_reset();
    n_vec++;
    if ({o_gnt, o_done, o_rdata, o_busy, o_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== 59'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h busy=%b err=%b en=%b we=%b addr=%h wd=%h, want all 0",
               o_gnt, o_done, o_rdata, o_busy, o_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    end
  endtask

  task automatic test_single_read();
    logic [2:0] g, d; logic [15:0] rdat, ma, mwd; logic mwe, e; int en, dc; bit held, idl;
    set_port(0, 1'b0, 16'h0010, 16'h0);
    i_req = 3'b001;
    run_txn(1, 16'hBEEF, 0, 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    i_req = '0;
    n_vec++;
    if ({g, d, ma, mwe, rdat} !== {3'b001, 3'b001, 16'h0010, 1'b0, 16'hBEEF}) begin
      n_err++;
      $display("FAIL read_txn: got gnt=%b done=%b addr=%h we=%b rdata=%h, want 001 001 0010 0 beef", g, d, ma, mwe, rdat);
    end
    n_vec++;
    if ({en, dc, 30'(held), 2'(idl)} !== {32'd1, 32'd2, 30'd1, 2'd1}) begin
      n_err++;
      $display("FAIL read_timing: got en_cycles=%0d done_at=%0d held=%0d idle=%0d, want 1 2 1 1", en, dc, held, idl);
    end
    ref_rdata = 16'hBEEF; ref_ptr = 1;
  endtask

  task automatic test_write();
    logic [2:0] g, d; logic [15:0] rdat, ma, mwd; logic mwe, e; int en, dc; bit held, idl;
    set_port(1, 1'b1, 16'h0100, 16'h1234);
    i_req = 3'b010;
    run_txn(3, 16'h5555, 1, 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    i_req = '0;
    n_vec++;
    if ({g, d, ma, mwe, mwd, rdat} !== {3'b010, 3'b010, 16'h0100, 1'b1, 16'h1234, ref_rdata}) begin
      n_err++;
      $display("FAIL write_txn: got gnt=%b done=%b addr=%h we=%b wd=%h rdata=%h, want 010 010 0100 1 1234 %h",
               g, d, ma, mwe, mwd, rdat, ref_rdata);
    end
    n_vec++;
    if ({en, dc, 30'(held), 2'(idl)} !== {32'd1, 32'd4, 30'd1, 2'd1}) begin
      n_err++;
      $display("FAIL write_timing: got en_cycles=%0d done_at=%0d held=%0d idle=%0d, want 1 4 1 1", en, dc, held, idl);
    end
    ref_ptr = 2;
  endtask

  task automatic test_round_robin();
    logic [2:0] g, d; logic [15:0] rdat, ma, mwd; logic mwe, e; int en, dc; bit held, idl;
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < 3; i++) set_port(i, 1'b0, 16'(16'h0A00 + i), 16'h0);
    i_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      run_txn(1, 16'(16'h1000 + t), exp_order[t], 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
      n_vec++;
      if ({g, d, ma, rdat} !== {3'b001 << exp_order[t], 3'b001 << exp_order[t],
                                 16'(16'h0A00 + exp_order[t]), 16'(16'h1000 + t)}) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got gnt=%b done=%b addr=%h rdata=%h, want requester %0d",
                 t, g, d, ma, rdat, exp_order[t]);
      end
    end
    i_req = '0;
    ref_ptr = 0; ref_rdata = 16'h1005;
  endtask

  task automatic test_reset_mid_wait();
    logic [2:0] g, d, dseen; logic [15:0] rdat, ma, mwd; logic mwe, e; int en, dc; bit held, idl;
    do_reset();
    set_port(0, 1'b0, 16'h0020, 16'h0);
    i_req = 3'b001;
    run_txn(1, 16'h0A0A, 0, 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    set_port(2, 1'b0, 16'h0222, 16'h0);
    i_req = 3'b100;
    tick(); tick();
    n_vec++;
    if ({o_busy, o_gnt, o_mem_en} !== {1'b1, 3'b100, 1'b0}) begin
      n_err++;
      $display("FAIL mid_wait_setup: got busy=%b gnt=%b en=%b, want 1 100 0", o_busy, o_gnt, o_mem_en);
    end
    reset = 1'b1;
    tick();
    dseen = o_done;
    reset = 1'b0; i_req = '0; i_mem_ack = 1'b1; i_mem_rdata = 16'hDEAD;
    tick();
    dseen |= o_done;
    i_mem_ack = 1'b0;
    tick();
    dseen |= o_done;
    n_vec++;
    if ({dseen, o_gnt, o_rdata, o_busy, o_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== 62'h0) begin
      n_err++;
      $display("FAIL mid_wait_reset: got done_seen=%b gnt=%b rdata=%h busy=%b err=%b en=%b addr=%h, want all 0",
               dseen, o_gnt, o_rdata, o_busy, o_err, o_mem_en, o_mem_addr);
    end
    ref_ptr = 0; ref_rdata = 16'h0;
    set_port(0, 1'b0, 16'h0030, 16'h0);
    i_req = 3'b101;
    run_txn(2, 16'h7777, ref_winner(3'b101, ref_ptr), 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    i_req = '0;
    n_vec++;
    if ({g, d, ma, rdat} !== {3'b001, 3'b001, 16'h0030, 16'h7777}) begin
      n_err++;
      $display("FAIL post_reset_grant: got gnt=%b done=%b addr=%h rdata=%h, want 001 001 0030 7777", g, d, ma, rdat);
    end
    ref_ptr = 1; ref_rdata = 16'h7777;
  endtask

  task automatic test_stray_ack();
    logic [2:0] dseen;
    i_req = '0;
    i_mem_ack = 1'b1; i_mem_rdata = 16'h4321;
    tick();
    dseen = o_done;
    i_mem_ack = 1'b0;
    tick();
    dseen |= o_done;
    n_vec++;
    if ({o_busy, o_gnt, dseen, o_mem_en, o_rdata} !== {1'b0, 3'b000, 3'b000, 1'b0, ref_rdata}) begin
      n_err++;
      $display("FAIL stray_ack: got busy=%b gnt=%b done=%b en=%b rdata=%h, want 0 000 000 0 %h",
               o_busy, o_gnt, dseen, o_mem_en, o_rdata, ref_rdata);
    end
  endtask

  task automatic test_random();
    logic [2:0] g, d, r; logic [15:0] rdat, ma, mwd, rd; logic mwe, e; int en, dc, lat, w; bit held, idl;
    logic we[3]; logic [15:0] ad[3], wd[3];
    for (int t = 0; t < 40; t++) begin
      r = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        we[i] = 1'($urandom); ad[i] = 16'($urandom); wd[i] = 16'($urandom);
        set_port(i, we[i], ad[i], wd[i]);
      end
      i_req = r;
      w = ref_winner(r, ref_ptr);
      lat = $urandom_range(1, 4);
      rd = 16'($urandom);
      run_txn(lat, rd, w, 1'($urandom), g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
      i_req = '0;
      n_vec++;
      if ({g, d, ma, mwe, mwd, rdat} !== {3'b001 << w, 3'b001 << w, ad[w], we[w], wd[w],
                                          we[w] ? ref_rdata : rd}) begin
        n_err++;
        $display("FAIL rand_txn[%0d]: got gnt=%b done=%b addr=%h we=%b wd=%h rdata=%h, want winner %0d addr=%h we=%b wd=%h rdata=%h",
                 t, g, d, ma, mwe, mwd, rdat, w, ad[w], we[w], wd[w], we[w] ? ref_rdata : rd);
      end
      n_vec++;
      if ({en, dc, 28'(held), 2'(idl), 2'(e)} !== {32'd1, 32'(lat + 1), 28'd1, 2'd1, 2'd0}) begin
        n_err++;
        $display("FAIL rand_timing[%0d]: got en_cycles=%0d done_at=%0d held=%0d idle=%0d err=%b, want 1 %0d 1 1 0",
                 t, en, dc, held, idl, e, lat + 1);
      end
      if (!we[w]) ref_rdata = rd;
      ref_ptr = (w + 1) % 3;
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] g, d; logic [15:0] rdat, ma, mwd; logic mwe, e; int en, dc; bit held, idl;
    do_reset();
    set_port(1, 1'b0, 16'h0040, 16'h0);
    i_req = 3'b010;
    run_txn(0, 16'h0, 1, 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    i_req = '0;
    n_vec++;
    if ({d, rdat, e, dc, 31'(idl)} !== {3'b010, 16'hFFFF, 1'b1, 32'(TB_TIMEOUT + 1), 31'd1}) begin
      n_err++;
      $display("FAIL timeout_abort: got done=%b rdata=%h err=%b done_at=%0d idle=%0d, want 010 ffff 1 %0d 1",
               d, rdat, e, dc, idl, TB_TIMEOUT + 1);
    end
    i_mem_ack = 1'b1; i_mem_rdata = 16'h3333;
    tick();
    i_mem_ack = 1'b0;
    set_port(0, 1'b0, 16'h0050, 16'h0);
    i_req = 3'b001;
    run_txn(2, 16'h6262, 0, 0, g, d, rdat, ma, mwe, mwd, en, dc, held, idl, e);
    i_req = '0;
    n_vec++;
    if ({d, rdat, e, o_err} !== {3'b001, 16'h6262, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL err_sticky: got done=%b rdata=%h err_done=%b err_now=%b, want 001 6262 1 1", d, rdat, e, o_err);
    end
    do_reset();
    n_vec++;
    if (o_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_cleared: got err=%b, want 0", o_err);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_reset_mid_wait();
    test_stray_ack();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
